mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, plus the MEM/WB boundary register. Consumes the EX→MEM register bundle, performs word loads and stores against a local data memory with configurable wait states, and registers the write-back bundle for the WB stage and the forwarding unit. While an access is waiting, it raises `stall` so the front of the pipeline holds.

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_stage_data_mem.sv | 27 ++
 rtl/mem_stage.sv | 112 +++++++++++
 tb/tb_mem_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory-access stage.
// WORD is the datapath width, REG_W the register-index width and
// DMEM_ADDR_W the default data-memory word-index width.
package mem_stage_pkg;

   localparam int WORD        = 32;
   localparam int REG_W       = 5;
   localparam int DMEM_ADDR_W = 8;

   // Wait-state controller view: IDLE when the counter is zero, BUSY otherwise.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mem_state_e;

   // Debug bundle exposed on the top-level dbg port.
   typedef struct packed {
      mem_state_e state;
      logic [3:0] cnt;
      logic [3:0] wait_cfg;
   } mem_dbg_t;

endpackage

// File: rtl/mem_stage_data_mem.sv
// Local data memory: 2^ADDR_W words, asynchronous read, synchronous write.
// Contents are not touched by reset.
module data_mem
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [WORD-1:0]   wdata,
   output logic [WORD-1:0]   rdata
);

   logic [WORD-1:0] mem [0:(1<<ADDR_W)-1];

   // Read is combinational so a load sees the contents before this edge's write.
   assign rdata = mem[idx];

   // Write the addressed word on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage plus MEM/WB boundary register.
// Build option: define MEM_WAIT_EN to add WAIT_CYC wait states per load/store
// with a combinational stall; without it every access completes in one cycle
// and stall is tied low.
//
// Handshake: stall is a hold request to upstream. While stall is high the
// upstream stage must keep every *_in signal stable; the instruction is
// accepted (and the output register loaded with its result) on the first
// rising edge where stall is low. Stalled edges load a bubble.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int WAIT_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WORD-1:0]  alu_in,
   input  logic [WORD-1:0]  st_data_in,
   input  logic             mem_w_in,
   input  logic             mem_r_in,
   input  logic             wb_en_in,
   input  logic             terminate_in,
   input  logic [REG_W-1:0] reg_dest_in,
   output logic             stall,
   output logic             wb_en_out,
   output logic             terminate_out,
   output logic [REG_W-1:0] reg_dest_out,
   output logic [WORD-1:0]  wb_data_out,
   output logic [8:0]       dbg
);

   logic [ADDR_W-1:0] idx;
   logic [WORD-1:0]   rdata;
   logic              we;
   logic [3:0]        cnt;
   mem_state_e        state;
   mem_dbg_t          dbg_s;

   // Byte address to word index; low two bits and high bits are dropped.
   assign idx = alu_in[ADDR_W+1:2];

`ifdef MEM_WAIT_EN
   logic acc;
   assign acc = mem_r_in | mem_w_in;

   // Wait counter: counts up while an access is pending, clears on completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= 4'd0;
      end else if (acc) begin
         if (cnt == WAIT_CYC[3:0]) begin
            cnt <= 4'd0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end else begin
         cnt <= 4'd0;
      end
   end

   // Hold upstream until the counter reaches the configured wait count.
   assign stall = rst & acc & (cnt != WAIT_CYC[3:0]);
`else
   assign cnt   = 4'd0;
   assign stall = 1'b0;
`endif

   assign state = (cnt == 4'd0) ? ST_IDLE : ST_BUSY;

   // Debug view of the wait-state controller.
   always_comb begin
      dbg_s          = '0;
      dbg_s.state    = state;
      dbg_s.cnt      = cnt;
      dbg_s.wait_cfg = WAIT_CYC[3:0];
   end
   assign dbg = dbg_s;

   // A store commits only on its completing edge and never while in reset,
   // so an interrupted store leaves memory untouched.
   assign we = rst & mem_w_in & ~stall;

   data_mem #(.ADDR_W(ADDR_W)) u_dmem (
      .clk   (clk),
      .we    (we),
      .idx   (idx),
      .wdata (st_data_in),
      .rdata (rdata)
   );

   // MEM/WB register: result on completing edges, bubble on stalled edges.
   // With both read and write set, the read path returns the pre-write word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_out     <= 1'b0;
         terminate_out <= 1'b0;
         reg_dest_out  <= '0;
         wb_data_out   <= '0;
      end else if (stall) begin
         wb_en_out     <= 1'b0;
         terminate_out <= 1'b0;
         reg_dest_out  <= '0;
      end else begin
         wb_en_out     <= wb_en_in;
         terminate_out <= terminate_in;
         reg_dest_out  <= reg_dest_in;
         wb_data_out   <= mem_r_in ? rdata : alu_in;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage. Works in both builds: LAT is the number of
// stalled cycles expected per memory instruction.
module tb_mem_stage;
   import mem_stage_pkg::*;

`ifdef MEM_WAIT_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic             clk;
   logic             rst;
   logic [WORD-1:0]  alu_in;
   logic [WORD-1:0]  st_data_in;
   logic             mem_w_in;
   logic             mem_r_in;
   logic             wb_en_in;
   logic             terminate_in;
   logic [REG_W-1:0] reg_dest_in;
   logic             stall;
   logic             wb_en_out;
   logic             terminate_out;
   logic [REG_W-1:0] reg_dest_out;
   logic [WORD-1:0]  wb_data_out;
   logic [8:0]       dbg;

   int tests_run = 0;
   int tests_failed = 0;
   logic [WORD-1:0] exp_q[$];
   logic [WORD-1:0] last_wb;

   mem_stage #(.ADDR_W(8), .WAIT_CYC(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .alu_in        (alu_in),
      .st_data_in    (st_data_in),
      .mem_w_in      (mem_w_in),
      .mem_r_in      (mem_r_in),
      .wb_en_in      (wb_en_in),
      .terminate_in  (terminate_in),
      .reg_dest_in   (reg_dest_in),
      .stall         (stall),
      .wb_en_out     (wb_en_out),
      .terminate_out (terminate_out),
      .reg_dest_out  (reg_dest_out),
      .wb_data_out   (wb_data_out),
      .dbg           (dbg)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("%s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      mem_r_in = 0; mem_w_in = 0; wb_en_in = 0; terminate_in = 0;
      reg_dest_in = '0; alu_in = '0; st_data_in = '0;
   endtask

   // Driver: issue one instruction at a negedge and check it through completion.
   task automatic do_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] alu, input logic [31:0] sd,
                        input logic wbe, input logic [4:0] dst, input logic term,
                        input logic [31:0] exp_data);
      int lat;
      logic [31:0] e;
      lat = (rd | wr) ? LAT : 0;
      exp_q.push_back(exp_data);
      @(negedge clk);
      mem_r_in = rd; mem_w_in = wr; alu_in = alu; st_data_in = sd;
      wb_en_in = wbe; reg_dest_in = dst; terminate_in = term;
      for (int i = 0; i < lat; i++) begin
         #1 chk({tag, " stall_hi"}, 32'(stall), 32'd1);
         @(posedge clk); #1;
         chk({tag, " bubble_wb_en"}, 32'(wb_en_out), 32'd0);
         chk({tag, " bubble_term"}, 32'(terminate_out), 32'd0);
         chk({tag, " bubble_dest"}, 32'(reg_dest_out), 32'd0);
         chk({tag, " bubble_hold"}, wb_data_out, last_wb);
         @(negedge clk);
      end
      #1 chk({tag, " stall_lo"}, 32'(stall), 32'd0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk({tag, " wb_data"}, wb_data_out, e);
      chk({tag, " wb_en"}, 32'(wb_en_out), 32'(wbe));
      chk({tag, " dest"}, 32'(reg_dest_out), 32'(dst));
      chk({tag, " term"}, 32'(terminate_out), 32'(term));
      last_wb = e;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " stall"}, 32'(stall), 32'd0);
      chk({tag, " wb_en"}, 32'(wb_en_out), 32'd0);
      chk({tag, " term"}, 32'(terminate_out), 32'd0);
      chk({tag, " dest"}, 32'(reg_dest_out), 32'd0);
      chk({tag, " wb_data"}, wb_data_out, 32'd0);
   endtask

   initial begin
      drive_idle();
      last_wb = '0;
      // Reset with a memory access requested: stall must still be low.
      rst = 1'b0;
      mem_r_in = 1'b1;
      #12;
      chk_reset_outs("reset");
      @(negedge clk);
      drive_idle();
      rst = 1'b1;

      // Store then load, plus a non-memory instruction.
      do_op("st10", 0, 1, 32'h10, 32'hDEADBEEF, 0, 5'd0, 0, 32'h10);
      do_op("ld10", 1, 0, 32'h10, 32'h0, 1, 5'd3, 0, 32'hDEADBEEF);
      do_op("alu",  0, 0, 32'h1234, 32'h0, 1, 5'd7, 0, 32'h1234);

      // Address wrap and ignored low bits: 0x403 maps to word 0.
      do_op("st403", 0, 1, 32'h403, 32'hCAFEF00D, 1, 5'd1, 0, 32'h403);
      do_op("ld000", 1, 0, 32'h000, 32'h0, 1, 5'd2, 0, 32'hCAFEF00D);
      do_op("ld400", 1, 0, 32'h400, 32'h0, 1, 5'd4, 0, 32'hCAFEF00D);
      do_op("ld10x", 1, 0, 32'h10, 32'h0, 1, 5'd5, 0, 32'hDEADBEEF);

      // Read and write together: store, returning the old word.
      do_op("rw10", 1, 1, 32'h10, 32'h55AA55AA, 1, 5'd9, 0, 32'hDEADBEEF);
      do_op("ld10b", 1, 0, 32'h13, 32'h0, 1, 5'd10, 0, 32'h55AA55AA);

      // Terminate bit on a store and on an ALU op, then cleared.
      do_op("st_term", 0, 1, 32'h44, 32'h0BADF00D, 0, 5'd0, 1, 32'h44);
      do_op("alu_term", 0, 0, 32'hABCD, 32'h0, 1, 5'd31, 1, 32'hABCD);
      do_op("alu_noterm", 0, 0, 32'h5555, 32'h0, 0, 5'd6, 0, 32'h5555);
      do_op("ld44", 1, 0, 32'h44, 32'h0, 1, 5'd8, 0, 32'h0BADF00D);

      // Reset during an in-flight store: memory must keep its old value.
      do_op("st20", 0, 1, 32'h20, 32'h11111111, 0, 5'd0, 0, 32'h20);
      @(negedge clk);
      mem_w_in = 1'b1; alu_in = 32'h20; st_data_in = 32'hBADBAD00;
      wb_en_in = 1'b1; reg_dest_in = 5'd12; terminate_in = 1'b1;
`ifdef MEM_WAIT_EN
      @(posedge clk); #2;
      chk("busy stall", 32'(stall), 32'd1);
`else
      #2;
`endif
      rst = 1'b0;
      #1 chk_reset_outs("mid_reset");
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      rst = 1'b1;
      last_wb = '0;
      do_op("ld20", 1, 0, 32'h20, 32'h0, 1, 5'd13, 0, 32'h11111111);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
